// File: rtl/mul_issue_ctrl.sv
// Shares one pipelined multiplier between two requesters.
// Credit-gated issue, shadow pipe tracking, in-order response FIFO.
module mul_issue_ctrl #(
  parameter int XLEN      = 32,
  parameter int TAG_W     = 4,
  parameter int MUL_LAT   = 2,
  parameter int BUF_DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [1:0]       req0_opcode,
  input  logic [XLEN-1:0]  req0_src1,
  input  logic [XLEN-1:0]  req0_src2,
  input  logic [TAG_W-1:0] req0_tag,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [1:0]       req1_opcode,
  input  logic [XLEN-1:0]  req1_src1,
  input  logic [XLEN-1:0]  req1_src2,
  input  logic [TAG_W-1:0] req1_tag,
  output logic             mul,
  output logic [1:0]       mul_opcode,
  output logic [XLEN-1:0]  mul_src1,
  output logic [XLEN-1:0]  mul_src2,
  input  logic [XLEN-1:0]  mul_result,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [TAG_W-1:0] rsp_tag,
  output logic [XLEN-1:0]  rsp_result
);

  localparam int CW = $clog2(BUF_DEPTH + 1);
  localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;

  logic [CW-1:0]      cnt_q, cnt_d;
  logic [CW-1:0]      fcnt_q, fcnt_d;
  logic [PW-1:0]      wptr_q, wptr_d;
  logic [PW-1:0]      rptr_q, rptr_d;
  logic               prio_q, prio_d;
  logic [MUL_LAT-1:0] sh_vld_q, sh_vld_d;
  logic [MUL_LAT-1:0] sh_id_q, sh_id_d;
  logic [TAG_W-1:0]   sh_tag_q [MUL_LAT];
  logic [TAG_W-1:0]   sh_tag_d [MUL_LAT];
  logic               buf_id_q [BUF_DEPTH];
  logic               buf_id_d [BUF_DEPTH];
  logic [TAG_W-1:0]   buf_tag_q [BUF_DEPTH];
  logic [TAG_W-1:0]   buf_tag_d [BUF_DEPTH];
  logic [XLEN-1:0]    buf_res_q [BUF_DEPTH];
  logic [XLEN-1:0]    buf_res_d [BUF_DEPTH];

  logic          pop;
  logic          wr;
  logic          issue_ok;
  logic          issue;
  logic          grant;
  logic [CW-1:0] avail;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(BUF_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign rsp_valid  = (fcnt_q != '0);
  assign rsp_id     = rsp_valid & buf_id_q[rptr_q];
  assign rsp_tag    = rsp_valid ? buf_tag_q[rptr_q] : '0;
  assign rsp_result = rsp_valid ? buf_res_q[rptr_q] : '0;

  assign pop      = rsp_valid & rsp_ready;
  assign avail    = cnt_q - CW'(pop);
  assign issue_ok = avail < CW'(BUF_DEPTH);
  assign wr       = sh_vld_q[MUL_LAT-1] & ~flush;

  always_comb begin
    grant = prio_q;
    unique case (1'b1)
      (req0_valid & ~req1_valid): grant = 1'b0;
      (req1_valid & ~req0_valid): grant = 1'b1;
      default:                    grant = prio_q;
    endcase
  end

  assign issue = (req0_valid | req1_valid) & issue_ok
               & ~flush & ~rst;

  assign req0_ready = issue & ~grant;
  assign req1_ready = issue & grant;
  assign mul        = issue;

  always_comb begin
    mul_opcode = '0;
    mul_src1   = '0;
    mul_src2   = '0;
    if (issue) begin
      mul_opcode = grant ? req1_opcode : req0_opcode;
      mul_src1   = grant ? req1_src1 : req0_src1;
      mul_src2   = grant ? req1_src2 : req0_src2;
    end
  end

  always_comb begin
    prio_d = issue ? ~grant : prio_q;
    cnt_d  = cnt_q + CW'(issue) - CW'(pop);
    if (flush) cnt_d = '0;
  end

  // Shadow of the multiplier pipe: stage 0 loads on issue.
  always_comb begin
    sh_vld_d    = sh_vld_q;
    sh_id_d     = sh_id_q;
    sh_tag_d    = sh_tag_q;
    sh_vld_d[0] = issue;
    sh_id_d[0]  = grant;
    sh_tag_d[0] = grant ? req1_tag : req0_tag;
    for (int i = 1; i < MUL_LAT; i++) begin
      sh_vld_d[i] = sh_vld_q[i-1];
      sh_id_d[i]  = sh_id_q[i-1];
      sh_tag_d[i] = sh_tag_q[i-1];
    end
    if (flush) sh_vld_d = '0;
  end

  always_comb begin
    buf_id_d  = buf_id_q;
    buf_tag_d = buf_tag_q;
    buf_res_d = buf_res_q;
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    fcnt_d    = fcnt_q + CW'(wr) - CW'(pop);
    if (wr) begin
      buf_id_d[wptr_q]  = sh_id_q[MUL_LAT-1];
      buf_tag_d[wptr_q] = sh_tag_q[MUL_LAT-1];
      buf_res_d[wptr_q] = mul_result;
      wptr_d            = ptr_inc(wptr_q);
    end
    if (pop) rptr_d = ptr_inc(rptr_q);
    if (flush) begin
      fcnt_d = '0;
      wptr_d = '0;
      rptr_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      fcnt_q   <= '0;
      wptr_q   <= '0;
      rptr_q   <= '0;
      prio_q   <= 1'b0;
      sh_vld_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      fcnt_q   <= fcnt_d;
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      prio_q   <= prio_d;
      sh_vld_q <= sh_vld_d;
    end
  end

  always_ff @(posedge clk) begin
    sh_id_q   <= sh_id_d;
    sh_tag_q  <= sh_tag_d;
    buf_id_q  <= buf_id_d;
    buf_tag_q <= buf_tag_d;
    buf_res_q <= buf_res_d;
  end

  always_ff @(posedge clk) begin
    if (!rst && wr) begin
      assert (fcnt_q != CW'(BUF_DEPTH));
    end
  end

endmodule

// File: tb/tb_mul_issue_ctrl.sv
// Directed bench for mul_issue_ctrl with a 2-stage multiplier model.
// Responses are scoreboarded against a queue of accepted ops.
module tb_mul_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst, flush;
  logic        req0_valid, req0_ready;
  logic [1:0]  req0_opcode;
  logic [31:0] req0_src1, req0_src2;
  logic [3:0]  req0_tag;
  logic        req1_valid, req1_ready;
  logic [1:0]  req1_opcode;
  logic [31:0] req1_src1, req1_src2;
  logic [3:0]  req1_tag;
  logic        mul;
  logic [1:0]  mul_opcode;
  logic [31:0] mul_src1, mul_src2, mul_result;
  logic        rsp_valid, rsp_ready, rsp_id;
  logic [3:0]  rsp_tag;
  logic [31:0] rsp_result;

  int total = 0;
  int bad = 0;
  int n_iss, n_rsp;
  logic expg;
  logic [31:0] k;

  typedef struct {
    logic        id;
    logic [3:0]  tag;
    logic [31:0] res;
  } exp_t;
  exp_t q[$];

  always #5 clk = ~clk;

  mul_issue_ctrl dut (
    .clk(clk), .rst(rst), .flush(flush),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_opcode(req0_opcode), .req0_src1(req0_src1),
    .req0_src2(req0_src2), .req0_tag(req0_tag),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_opcode(req1_opcode), .req1_src1(req1_src1),
    .req1_src2(req1_src2), .req1_tag(req1_tag),
    .mul(mul), .mul_opcode(mul_opcode),
    .mul_src1(mul_src1), .mul_src2(mul_src2),
    .mul_result(mul_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_tag(rsp_tag),
    .rsp_result(rsp_result)
  );

  function automatic logic [31:0] mul_ref(
    input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] xa, xb, p;
    xa = (op == 2'b11) ? {32'h0, a} : {{32{a[31]}}, a};
    xb = op[1] ? {32'h0, b} : {{32{b[31]}}, b};
    p  = xa * xb;
    return (op == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  logic [31:0] m1, m2;
  always_ff @(posedge clk) begin
    m1 <= mul_ref(mul_opcode, mul_src1, mul_src2);
    m2 <= m1;
  end
  assign mul_result = m2;

  task automatic chk(input string nm, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", nm, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  task automatic sb_step(input string nm);
    exp_t e;
    if (req0_ready || req1_ready) begin
      e.id  = req1_ready;
      e.tag = req1_ready ? req1_tag : req0_tag;
      e.res = req1_ready ?
              mul_ref(req1_opcode, req1_src1, req1_src2) :
              mul_ref(req0_opcode, req0_src1, req0_src2);
      q.push_back(e);
      n_iss++;
    end
    if (rsp_valid && rsp_ready) begin
      chk({nm, "_q_nonempty"}, 64'(q.size() > 0), 64'd1);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk({nm, "_id"}, 64'(rsp_id), 64'(e.id));
        chk({nm, "_tag"}, 64'(rsp_tag), 64'(e.tag));
        chk({nm, "_res"}, 64'(rsp_result), 64'(e.res));
      end
      n_rsp++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1; flush = 0; rsp_ready = 0;
    req0_valid = 1; req0_opcode = 0; req0_src1 = 5;
    req0_src2 = 5; req0_tag = 1;
    req1_valid = 0; req1_opcode = 0; req1_src1 = 0;
    req1_src2 = 0; req1_tag = 0;
    tick; tick;
    settle;
    chk("rst_rsp_valid", 64'(rsp_valid), 0);
    chk("rst_mul", 64'(mul), 0);
    chk("rst_ready0", 64'(req0_ready), 0);
    chk("rst_ready1", 64'(req1_ready), 0);
    chk("rst_mul_src1", 64'(mul_src1), 0);
    chk("rst_mul_op", 64'(mul_opcode), 0);
    chk("rst_rsp_res", 64'(rsp_result), 0);
    chk("rst_rsp_tag", 64'(rsp_tag), 0);

    // single MUL 3x5
    rst = 0; rsp_ready = 1;
    req0_src1 = 3; req0_src2 = 5; req0_tag = 7;
    settle;
    chk("t1_mul", 64'(mul), 1);
    chk("t1_ready0", 64'(req0_ready), 1);
    chk("t1_ready1", 64'(req1_ready), 0);
    chk("t1_src1", 64'(mul_src1), 3);
    chk("t1_src2", 64'(mul_src2), 5);
    chk("t1_op", 64'(mul_opcode), 0);
    tick; req0_valid = 0; settle;
    chk("t1_rv_t1", 64'(rsp_valid), 0);
    tick; settle;
    chk("t1_rv_t2", 64'(rsp_valid), 0);
    tick; settle;
    chk("t1_rv_t3", 64'(rsp_valid), 1);
    chk("t1_res", 64'(rsp_result), 64'h0000000F);
    chk("t1_id", 64'(rsp_id), 0);
    chk("t1_tag", 64'(rsp_tag), 7);
    tick; settle;
    chk("t1_rv_t4", 64'(rsp_valid), 0);

    // MULH / MULHU / MULHSU on all-ones
    req0_valid = 1; req0_opcode = 2'b01;
    req0_src1 = 32'hFFFFFFFF; req0_src2 = 32'hFFFFFFFF;
    req0_tag = 1;
    settle; chk("t2_rdy_a0", 64'(req0_ready), 1);
    tick; req0_opcode = 2'b11; req0_tag = 2;
    settle; chk("t2_rdy_a1", 64'(req0_ready), 1);
    tick; req0_opcode = 2'b10; req0_tag = 3;
    settle; chk("t2_stall_a2", 64'(req0_ready), 0);
    tick; settle;
    chk("t2_rdy_a3", 64'(req0_ready), 1);
    chk("t2_rv_a3", 64'(rsp_valid), 1);
    chk("t2_mulh", 64'(rsp_result), 64'h00000000);
    chk("t2_tag_a3", 64'(rsp_tag), 1);
    tick; req0_valid = 0; settle;
    chk("t2_rv_a4", 64'(rsp_valid), 1);
    chk("t2_mulhu", 64'(rsp_result), 64'hFFFFFFFE);
    chk("t2_tag_a4", 64'(rsp_tag), 2);
    tick; settle;
    chk("t2_rv_a5", 64'(rsp_valid), 0);
    tick; settle;
    chk("t2_rv_a6", 64'(rsp_valid), 1);
    chk("t2_mulhsu", 64'(rsp_result), 64'hFFFFFFFF);
    chk("t2_tag_a6", 64'(rsp_tag), 3);
    tick; settle;
    chk("t2_rv_a7", 64'(rsp_valid), 0);

    // round robin, both requesters always valid
    rst = 1; tick;
    rst = 0;
    req0_valid = 1; req1_valid = 1;
    req0_opcode = 0; req1_opcode = 0;
    req0_tag = 4'hA; req1_tag = 4'hB;
    req0_src2 = 3; req1_src2 = 7;
    expg = 0; n_iss = 0; n_rsp = 0;
    for (int c = 0; c < 12; c++) begin
      req0_src1 = 32'(c + 1);
      req1_src1 = 32'(c + 1);
      settle;
      if (req0_ready || req1_ready) begin
        chk("rr_grant", 64'(req1_ready), 64'(expg));
        chk("rr_mul", 64'(mul), 1);
      end
      sb_step("rr");
      if (req0_ready || req1_ready) expg = ~expg;
      tick;
    end
    req0_valid = 0; req1_valid = 0;
    for (int c = 0; c < 5; c++) begin
      settle; sb_step("rr"); tick;
    end
    chk("rr_n_iss", 64'(n_iss), 8);
    chk("rr_n_rsp", 64'(n_rsp), 8);

    // backpressure: credits cap accepted ops
    rsp_ready = 0;
    req0_valid = 1; req0_opcode = 0; req0_src2 = 10;
    k = 1; n_iss = 0; n_rsp = 0;
    for (int c = 0; c < 6; c++) begin
      req0_src1 = k; req0_tag = k[3:0];
      settle;
      chk("bp_ready", 64'(req0_ready), 64'(c < 2));
      if (c >= 3) begin
        chk("bp_hold_v", 64'(rsp_valid), 1);
        chk("bp_hold_res", 64'(rsp_result), 10);
      end
      if (req0_ready) begin
        sb_step("bp");
        k++;
      end
      tick;
    end
    rsp_ready = 1;
    req0_src1 = k; req0_tag = k[3:0];
    settle;
    chk("bp_resume", 64'(req0_ready), 1);
    sb_step("bp");
    if (req0_ready) k++;
    tick;
    for (int c = 0; c < 3; c++) begin
      req0_src1 = k; req0_tag = k[3:0];
      settle; sb_step("bp");
      if (req0_ready) k++;
      tick;
    end
    req0_valid = 0;
    for (int c = 0; c < 6; c++) begin
      settle; sb_step("bp"); tick;
    end
    chk("bp_n_iss", 64'(n_iss), 5);
    chk("bp_n_rsp", 64'(n_rsp), 5);

    // flush with one buffered and one in flight
    rsp_ready = 0;
    req0_valid = 1; req0_src1 = 2; req0_src2 = 2; req0_tag = 1;
    tick;
    req0_src1 = 2; req0_src2 = 3; req0_tag = 2;
    tick;
    req0_valid = 0;
    tick;
    flush = 1; rsp_ready = 1;
    req0_valid = 1; req0_src1 = 3; req0_src2 = 3; req0_tag = 9;
    settle;
    chk("fl_rv_buf", 64'(rsp_valid), 1);
    chk("fl_ready", 64'(req0_ready), 0);
    chk("fl_mul", 64'(mul), 0);
    tick; flush = 0; settle;
    chk("fl_rv_f4", 64'(rsp_valid), 0);
    chk("fl_rdy_f4", 64'(req0_ready), 1);
    tick; req0_src2 = 4; req0_tag = 10; settle;
    chk("fl_rv_f5", 64'(rsp_valid), 0);
    chk("fl_rdy_f5", 64'(req0_ready), 1);
    tick; req0_valid = 0; settle;
    chk("fl_rv_f6", 64'(rsp_valid), 0);
    tick; settle;
    chk("fl_rv_f7", 64'(rsp_valid), 1);
    chk("fl_res_f7", 64'(rsp_result), 9);
    chk("fl_tag_f7", 64'(rsp_tag), 9);
    tick; settle;
    chk("fl_res_f8", 64'(rsp_result), 12);
    chk("fl_tag_f8", 64'(rsp_tag), 10);
    tick; settle;
    chk("fl_rv_f9", 64'(rsp_valid), 0);

    // reset with ops in flight and a valid response
    rsp_ready = 0;
    req0_valid = 1; req0_src1 = 5; req0_src2 = 5; req0_tag = 3;
    tick;
    req0_src2 = 6; req0_tag = 4;
    tick;
    req0_valid = 0;
    tick;
    settle;
    chk("rs_rv_pre", 64'(rsp_valid), 1);
    rst = 1; req0_valid = 1; req1_valid = 1;
    settle;
    chk("rs_rdy0", 64'(req0_ready), 0);
    chk("rs_rdy1", 64'(req1_ready), 0);
    chk("rs_mul", 64'(mul), 0);
    tick; settle;
    chk("rs_rv_post", 64'(rsp_valid), 0);
    chk("rs_rdy0_b", 64'(req0_ready), 0);
    tick;
    rst = 0; rsp_ready = 1;
    req0_src1 = 6; req0_src2 = 7; req0_tag = 5;
    req1_src1 = 1; req1_src2 = 1; req1_tag = 6;
    settle;
    chk("rs_rr_rdy0", 64'(req0_ready), 1);
    chk("rs_rr_rdy1", 64'(req1_ready), 0);
    tick; req0_valid = 0; req1_valid = 0; settle;
    chk("rs_rv_r6", 64'(rsp_valid), 0);
    tick; settle;
    chk("rs_rv_r7", 64'(rsp_valid), 0);
    tick; settle;
    chk("rs_rv_r8", 64'(rsp_valid), 1);
    chk("rs_res", 64'(rsp_result), 42);
    chk("rs_id", 64'(rsp_id), 0);
    chk("rs_tag", 64'(rsp_tag), 5);
    tick; settle;
    chk("rs_rv_r9", 64'(rsp_valid), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
